tlb_search_arbiter: RTL and testbench

Sequencer and arbiter for the single shared TLB search port. Three requesters miss in their own buffers and need a lookup: the instruction-side TLB buffer, the data-side TLB buffer and the CP0 TLBP probe. The block serialises their lookups onto the port, captures the TLB's combinational result into registers, and returns a one-cycle done pulse plus the entry to the winner. It sits between the MEM1/IF buffer logic and the TLB array, and suppresses lookups around TLB writes and pipeline flushes.

---
 rtl/tlb_search_arbiter_if.sv | 37 +++
 rtl/tlb_search_arbiter.sv | 148 ++++++++++++++
 tb/tb_tlb_search_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_search_arbiter_if.sv
// Requester-side bundle of the shared TLB search port: I/D/P lookup
// requests with their VPN2, one-cycle done pulses and the registered result.
interface tlb_search_arbiter_if #(
  parameter int ENTRY_W = 78,
  parameter int TLBNUM  = 16
);
  localparam int IDX_W = $clog2(TLBNUM);

  logic               i_req;
  logic [18:0]        i_vpn2;
  logic               d_req;
  logic [18:0]        d_vpn2;
  logic               p_req;
  logic [18:0]        p_vpn2;
  logic               i_done;
  logic               d_done;
  logic               p_done;
  logic               rsp_found;
  logic [ENTRY_W-1:0] rsp_entry;
  logic [IDX_W-1:0]   rsp_index;

  modport master (
    output i_req, i_vpn2,
    output d_req, d_vpn2,
    output p_req, p_vpn2,
    input  i_done, d_done, p_done,
    input  rsp_found, rsp_entry, rsp_index
  );

  modport slave (
    input  i_req, i_vpn2,
    input  d_req, d_vpn2,
    input  p_req, p_vpn2,
    output i_done, d_done, p_done,
    output rsp_found, rsp_entry, rsp_index
  );
endinterface

// File: rtl/tlb_search_arbiter.sv
// Serialises I-buffer, D-buffer and TLBP lookups onto the single TLB
// search port (IDLE -> LOOKUP -> DONE), registering the combinational
// result and pulsing done to the winner.
// Ports: clk, rst (async, active-low), bus (requests/done/result),
// tlb_flush, tlb_wr, s_vpn2/s_found/s_entry/s_index (TLB side), busy.
module tlb_search_arbiter #(
  parameter int ENTRY_W = 78,
  parameter int TLBNUM  = 16,
  localparam int IDX_W  = $clog2(TLBNUM)
) (
  input  logic               clk,
  input  logic               rst,
  tlb_search_arbiter_if.slave bus,
  input  logic               tlb_flush,
  input  logic               tlb_wr,
  output logic [18:0]        s_vpn2,
  input  logic               s_found,
  input  logic [ENTRY_W-1:0] s_entry,
  input  logic [IDX_W-1:0]   s_index,
  output logic               busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;
  localparam logic [1:0] OWN_P    = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [1:0]         owner_q, owner_d;
  logic               rr_q, rr_d;
  logic [18:0]        vpn_q, vpn_d;
  logic               found_q, found_d;
  logic [ENTRY_W-1:0] entry_q, entry_d;
  logic [IDX_W-1:0]   index_q, index_d;

  logic i_v, d_v;
  logic pick_p, pick_i, pick_d;
  logic own_id;
  logic in_done;

  // flush masks I/D in the grant cycle; rr=1 lets I win a tie
  assign i_v    = bus.i_req & ~tlb_flush;
  assign d_v    = bus.d_req & ~tlb_flush;
  assign pick_p = bus.p_req;
  assign pick_i = ~pick_p & i_v & (~d_v | rr_q);
  assign pick_d = ~pick_p & d_v & (~i_v | ~rr_q);
  assign own_id = (owner_q == OWN_I) | (owner_q == OWN_D);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    vpn_d   = vpn_q;
    found_d = found_q;
    entry_d = entry_q;
    index_d = index_q;
    unique case (state_q)
      ST_IDLE: begin
        owner_d = OWN_NONE;
        if (!tlb_wr) begin
          unique case (1'b1)
            pick_p: begin
              owner_d = OWN_P;
              vpn_d   = bus.p_vpn2;
              state_d = ST_LOOKUP;
            end
            pick_i: begin
              owner_d = OWN_I;
              vpn_d   = bus.i_vpn2;
              state_d = ST_LOOKUP;
            end
            pick_d: begin
              owner_d = OWN_D;
              vpn_d   = bus.d_vpn2;
              state_d = ST_LOOKUP;
            end
            default: ;
          endcase
        end
      end
      ST_LOOKUP: begin
        if (tlb_wr) begin
          // array changing under us: drop result, requester re-arbitrates
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
        end else begin
          found_d = s_found;
          entry_d = s_entry;
          index_d = s_index;
          if (tlb_flush && own_id) begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
        if (owner_q == OWN_I) rr_d = 1'b0;
        if (owner_q == OWN_D) rr_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
      rr_q    <= 1'b0;
      vpn_q   <= '0;
      found_q <= 1'b0;
      entry_q <= '0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      vpn_q   <= vpn_d;
      found_q <= found_d;
      entry_q <= entry_d;
      index_q <= index_d;
    end
  end

  // done decoded from flopped state/owner; flush kills I/D pulse only
  assign in_done    = (state_q == ST_DONE);
  assign bus.i_done = in_done & (owner_q == OWN_I) & ~tlb_flush;
  assign bus.d_done = in_done & (owner_q == OWN_D) & ~tlb_flush;
  assign bus.p_done = in_done & (owner_q == OWN_P);

  assign bus.rsp_found = found_q;
  assign bus.rsp_entry = entry_q;
  assign bus.rsp_index = index_q;

  assign s_vpn2 = vpn_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tlb_search_arbiter.sv
// Directed bench for tlb_search_arbiter with a small combinational
// TLB model hanging off s_vpn2.
module tb_tlb_search_arbiter;
  localparam int ENTRY_W = 78;
  localparam int TLBNUM  = 16;
  localparam int IDX_W   = 4;

  localparam logic [2:0] DN_0 = 3'b000;
  localparam logic [2:0] DN_I = 3'b001;
  localparam logic [2:0] DN_D = 3'b010;
  localparam logic [2:0] DN_P = 3'b100;

  localparam logic [58:0] TAG_A = 59'h1_2345_6789_ABCD;
  localparam logic [58:0] TAG_B = 59'h7_0000_DEAD_BEEF;

  logic               clk = 1'b0;
  logic               rst;
  logic               tlb_flush;
  logic               tlb_wr;
  logic [18:0]        s_vpn2;
  logic               s_found;
  logic [ENTRY_W-1:0] s_entry;
  logic [IDX_W-1:0]   s_index;
  logic               busy;
  logic [58:0]        ent_tag;

  int n_run  = 0;
  int n_fail = 0;

  tlb_search_arbiter_if #(.ENTRY_W(ENTRY_W), .TLBNUM(TLBNUM)) rq ();

  tlb_search_arbiter #(.ENTRY_W(ENTRY_W), .TLBNUM(TLBNUM)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (rq),
    .tlb_flush (tlb_flush),
    .tlb_wr    (tlb_wr),
    .s_vpn2    (s_vpn2),
    .s_found   (s_found),
    .s_entry   (s_entry),
    .s_index   (s_index),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // TLB model: 7FFFF misses, index = vpn[3:0]+4, entry = {vpn, tag}
  assign s_found = (s_vpn2 != 19'h7FFFF);
  assign s_index = s_vpn2[3:0] + 4'd4;
  assign s_entry = {s_vpn2, ent_tag};

  task automatic check(input string tag,
                       input logic [95:0] got,
                       input logic [95:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] dn();
    return {rq.p_done, rq.d_done, rq.i_done};
  endfunction

  task automatic ne();
    @(negedge clk);
  endtask

  task automatic do_reset();
    ne();
    rst = 1'b0;
    ne();
    ne();
    check("rst_busy", 96'(busy), 96'(0));
    check("rst_vpn", 96'(s_vpn2), 96'(0));
    check("rst_found", 96'(rq.rsp_found), 96'(0));
    check("rst_entry", 96'(rq.rsp_entry), 96'(0));
    check("rst_index", 96'(rq.rsp_index), 96'(0));
    check("rst_done", 96'(dn()), 96'(DN_0));
    rst = 1'b1;
  endtask

  int cyc;
  logic [2:0] kinds [$];
  int at [$];

  initial begin
    rst = 1'b0;
    tlb_flush = 1'b0;
    tlb_wr = 1'b0;
    ent_tag = TAG_A;
    rq.i_req = 1'b0;
    rq.i_vpn2 = '0;
    rq.d_req = 1'b0;
    rq.d_vpn2 = '0;
    rq.p_req = 1'b0;
    rq.p_vpn2 = '0;

    // single D miss
    do_reset();
    rq.d_req = 1'b1;
    rq.d_vpn2 = 19'h00401;
    ne();
    check("d1_vpn", 96'(s_vpn2), 96'(19'h00401));
    check("d1_busy", 96'(busy), 96'(1));
    check("d1_nodone", 96'(dn()), 96'(DN_0));
    ne();
    check("d1_done", 96'(dn()), 96'(DN_D));
    check("d1_found", 96'(rq.rsp_found), 96'(1));
    check("d1_index", 96'(rq.rsp_index), 96'(5));
    check("d1_entry", 96'(rq.rsp_entry), 96'({19'h00401, TAG_A}));
    rq.d_req = 1'b0;
    ne();
    check("d1_pulse", 96'(dn()), 96'(DN_0));
    check("d1_idle", 96'(busy), 96'(0));

    // I and D together from reset: D, I, D, 3 cycles apart
    do_reset();
    rq.i_req = 1'b1;
    rq.i_vpn2 = 19'h00010;
    rq.d_req = 1'b1;
    rq.d_vpn2 = 19'h00020;
    for (int k = 1; k <= 8; k++) begin
      ne();
      if (dn() != DN_0) begin
        kinds.push_back(dn());
        at.push_back(k);
      end
    end
    check("rr_count", 96'(kinds.size()), 96'(3));
    if (kinds.size() == 3) begin
      check("rr_1st", 96'(kinds[0]), 96'(DN_D));
      check("rr_2nd", 96'(kinds[1]), 96'(DN_I));
      check("rr_3rd", 96'(kinds[2]), 96'(DN_D));
      check("rr_at1", 96'(at[0]), 96'(2));
      check("rr_gap1", 96'(at[1] - at[0]), 96'(3));
      check("rr_gap2", 96'(at[2] - at[1]), 96'(3));
    end

    // probe raised during I lookup preempts at next IDLE
    ne();
    ne();
    check("pp_ivpn", 96'(s_vpn2), 96'(19'h00010));
    rq.p_req = 1'b1;
    rq.p_vpn2 = 19'h7FFFF;
    ne();
    check("pp_idone", 96'(dn()), 96'(DN_I));
    ne();
    check("pp_idle", 96'(busy), 96'(0));
    ne();
    check("pp_pvpn", 96'(s_vpn2), 96'(19'h7FFFF));
    ne();
    check("pp_pdone", 96'(dn()), 96'(DN_P));
    check("pp_miss", 96'(rq.rsp_found), 96'(0));
    rq.p_req = 1'b0;
    ne();
    ne();
    check("pp_rr", 96'(s_vpn2), 96'(19'h00020));
    ne();
    check("pp_ddone", 96'(dn()), 96'(DN_D));
    rq.i_req = 1'b0;
    rq.d_req = 1'b0;
    ne();
    ne();

    // flush in LOOKUP cancels D
    rq.d_req = 1'b1;
    rq.d_vpn2 = 19'h00123;
    ne();
    check("fl_vpn", 96'(s_vpn2), 96'(19'h00123));
    tlb_flush = 1'b1;
    ne();
    check("fl_nodone", 96'(dn()), 96'(DN_0));
    check("fl_idle", 96'(busy), 96'(0));
    tlb_flush = 1'b0;
    rq.d_req = 1'b0;
    ne();
    check("fl_quiet", 96'(dn()), 96'(DN_0));
    // probe survives flush through LOOKUP and DONE
    rq.p_req = 1'b1;
    rq.p_vpn2 = 19'h00055;
    ne();
    tlb_flush = 1'b1;
    ne();
    check("fl_pdone", 96'(dn()), 96'(DN_P));
    check("fl_pidx", 96'(rq.rsp_index), 96'(9));
    tlb_flush = 1'b0;
    rq.p_req = 1'b0;
    ne();

    // write collision on I lookup, writer holds wr two cycles
    rq.i_req = 1'b1;
    rq.i_vpn2 = 19'h00077;
    ne();
    check("wr_vpn", 96'(s_vpn2), 96'(19'h00077));
    tlb_wr = 1'b1;
    ent_tag = TAG_B;
    ne();
    check("wr_nodone", 96'(dn()), 96'(DN_0));
    check("wr_idle", 96'(busy), 96'(0));
    ne();
    check("wr_hold", 96'(busy), 96'(0));
    tlb_wr = 1'b0;
    ne();
    check("wr_regrant", 96'(busy), 96'(1));
    check("wr_nodone2", 96'(dn()), 96'(DN_0));
    cyc = 0;
    while (dn() == DN_0 && cyc < 10) begin
      ne();
      cyc++;
    end
    check("wr_late", 96'(cyc), 96'(1));
    check("wr_idone", 96'(dn()), 96'(DN_I));
    check("wr_entry", 96'(rq.rsp_entry), 96'({19'h00077, TAG_B}));
    rq.i_req = 1'b0;
    ne();

    // async reset in the middle of a LOOKUP
    rq.d_req = 1'b1;
    rq.d_vpn2 = 19'h00300;
    ne();
    check("ar_busy", 96'(busy), 96'(1));
    #2;
    rst = 1'b0;
    #1;
    check("ar_busy0", 96'(busy), 96'(0));
    check("ar_vpn0", 96'(s_vpn2), 96'(0));
    check("ar_entry0", 96'(rq.rsp_entry), 96'(0));
    check("ar_done0", 96'(dn()), 96'(DN_0));
    ne();
    check("ar_nodone", 96'(dn()), 96'(DN_0));
    ne();
    rst = 1'b1;
    ne();
    check("ar_vpn", 96'(s_vpn2), 96'(19'h00300));
    ne();
    check("ar_ddone", 96'(dn()), 96'(DN_D));
    check("ar_index", 96'(rq.rsp_index), 96'(4));
    rq.d_req = 1'b0;
    ne();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
